// File: rtl/acc_add_sched.sv
// Add-port scheduler for the running total/count accumulator: debounces the
// front-panel add button, arbitrates it against a host valid/ready port and paces add/clear strobes.
module acc_add_sched #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_n,
    input  logic [WIDTH-1:0] SW,
    input  logic             clr,
    input  logic             host_valid,
    input  logic [WIDTH-1:0] host_data,
    output logic             host_ready,
    output logic             acc_add,
    output logic [WIDTH-1:0] acc_operand,
    output logic             acc_clr,
    output logic             grant_src,
    output logic             btn_drop
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF, CLEAR} state_t;

    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_HOST = 1'b1;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HO_LAST = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic          sync1, btn_s, db;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] ho_cnt;
    logic          btn_pend, clr_pend, clr_pend_nxt, rr_last;
    logic          grant_btn, grant_host, db_fall;

    // Accepted press: released debounced state meets its final agreeing sample.
    assign db_fall = db && !btn_s && (db_cnt == DB_LAST);

    // NOTE: add_n is asynchronous, so only btn_s (second flop) may feed any logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            btn_s  <= 1'b1;
            db     <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync1 <= add_n;
            btn_s <= sync1;
            if (btn_s == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        grant_btn    = 1'b0;
        grant_host   = 1'b0;
        clr_pend_nxt = clr_pend;
        case (state)
            IDLE: begin
                if (clr || clr_pend) begin
                    state_nxt    = CLEAR;
                    clr_pend_nxt = 1'b0;
                end else if (btn_pend && host_valid) begin
                    grant_btn  = (rr_last == SRC_HOST);
                    grant_host = (rr_last == SRC_BTN);
                end else begin
                    grant_btn  = btn_pend;
                    grant_host = host_valid;
                end
                if (grant_btn || grant_host) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = (HOLDOFF_CYCLES > 0) ? HOLDOFF : IDLE;
            HOLDOFF: if (ho_cnt == HO_LAST) state_nxt = IDLE;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && clr) clr_pend_nxt = 1'b1;
    end

    // Strobes are decoded from the next state so they are registered yet still
    // coincide with the cycle spent in ISSUE or CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_pend    <= 1'b0;
            clr_pend    <= 1'b0;
            rr_last     <= SRC_HOST;
            ho_cnt      <= '0;
            acc_add     <= 1'b0;
            acc_clr     <= 1'b0;
            host_ready  <= 1'b0;
            acc_operand <= '0;
            grant_src   <= SRC_BTN;
            btn_drop    <= 1'b0;
        end else begin
            clr_pend   <= clr_pend_nxt;
            acc_add    <= grant_btn || grant_host;
            host_ready <= grant_host;
            acc_clr    <= (state_nxt == CLEAR);
            btn_drop   <= db_fall && btn_pend && !grant_btn;
            ho_cnt     <= (state == HOLDOFF) ? ho_cnt + 1'b1 : '0;
            // A new press in the same cycle as a button grant becomes the next request.
            if (db_fall)        btn_pend <= 1'b1;
            else if (grant_btn) btn_pend <= 1'b0;
            if (grant_btn || grant_host) begin
                acc_operand <= grant_host ? host_data : SW;
                grant_src   <= grant_host;
                rr_last     <= grant_host;
            end
        end
    end

endmodule

// File: tb/tb_acc_add_sched.sv
// Self-checking bench for acc_add_sched: cycle table for reset/button timing,
// hand-written sequences for host streaming, contention, clear, drop and a 512-press run.
module tb_acc_add_sched;

    logic       clk, rst, add_n, clr, host_valid;
    logic [7:0] SW, host_data;
    logic       host_ready, acc_add, acc_clr, grant_src, btn_drop;
    logic [7:0] acc_operand;

    logic       add_n2;
    logic       host_ready2, acc_add2, acc_clr2, grant_src2, btn_drop2;
    logic [7:0] acc_operand2;

    int checks = 0, failures = 0, cyc = 0;
    int add_cnt = 0, clr_cnt = 0, drop_cnt = 0, both_cnt = 0;
    int add2_cnt = 0, drop2_cnt = 0, bad2_op = 0;

    acc_add_sched #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .add_n(add_n), .SW(SW), .clr(clr),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .acc_add(acc_add), .acc_operand(acc_operand), .acc_clr(acc_clr),
        .grant_src(grant_src), .btn_drop(btn_drop)
    );

    acc_add_sched #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .add_n(add_n2), .SW(8'h80), .clr(1'b0),
        .host_valid(1'b0), .host_data(8'h00), .host_ready(host_ready2),
        .acc_add(acc_add2), .acc_operand(acc_operand2), .acc_clr(acc_clr2),
        .grant_src(grant_src2), .btn_drop(btn_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, add_n, clr, hv;
        logic [7:0] sw;
        logic       e_add, e_clr, e_rdy, e_src;
        logic [7:0] e_op;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_rows(input int n, input logic r, input logic a, input logic c,
                                     input logic h, input logic [7:0] sw, input logic e_add,
                                     input logic e_clr, input logic [7:0] e_op);
        vec_t v;
        v.rst = r; v.add_n = a; v.clr = c; v.hv = h; v.sw = sw;
        v.e_add = e_add; v.e_clr = e_clr; v.e_rdy = 1'b0; v.e_src = 1'b0; v.e_op = e_op;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (acc_add === 1'b1) add_cnt++;
        if (acc_clr === 1'b1) clr_cnt++;
        if (btn_drop === 1'b1) drop_cnt++;
        if (acc_add === 1'b1 && acc_clr === 1'b1) both_cnt++;
        if (acc_add2 === 1'b1) begin
            add2_cnt++;
            if (acc_operand2 !== 8'h80) bad2_op++;
        end
        if (btn_drop2 === 1'b1) drop2_cnt++;
    endtask

    task automatic wait_add(input int budget, output int t);
        t = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (acc_add === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("add_within_budget", (t >= 0), 1);
    endtask

    // Button debounces with host_valid raised exactly when btn_pend becomes visible to IDLE.
    task automatic contend(input logic host_first);
        int t1, t2;
        add_n = 1'b0;
        repeat (6) tick();
        check("cont_no_early_add", acc_add, 0);
        host_valid = 1'b1;
        host_data  = 8'hC3;
        tick();
        t1 = cyc;
        check("cont_first_add", acc_add, 1);
        check("cont_first_src", grant_src, host_first);
        check("cont_first_ready", host_ready, host_first);
        check("cont_first_op", acc_operand, host_first ? 8'hC3 : 8'h3C);
        if (host_first) host_valid = 1'b0;
        wait_add(10, t2);
        check("cont_gap", t2 - t1, 4);
        check("cont_second_src", grant_src, !host_first);
        check("cont_second_ready", host_ready, !host_first);
        check("cont_second_op", acc_operand, host_first ? 8'h3C : 8'hC3);
        host_valid = 1'b0;
        add_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        int t1, t2, a0, c0, d0;
        add_n2    = 1'b1;
        host_data = 8'h33;

        // Reset with every request active, then clear first and a button add at E0+6.
        add_rows(3, 1, 0, 1, 1, 8'h01, 0, 0, 8'h00);
        add_rows(1, 0, 0, 1, 0, 8'h01, 0, 1, 8'h00);
        add_rows(5, 0, 0, 0, 0, 8'h01, 0, 0, 8'h00);
        add_rows(1, 0, 0, 0, 0, 8'h01, 1, 0, 8'h01);
        add_rows(2, 0, 0, 0, 0, 8'hFF, 0, 0, 8'h01);
        add_rows(1, 0, 0, 0, 0, 8'h55, 0, 0, 8'h01);
        add_rows(7, 0, 1, 0, 0, 8'h55, 0, 0, 8'h01);
        add_rows(3, 0, 0, 0, 0, 8'h55, 0, 0, 8'h01);
        add_rows(6, 0, 1, 0, 0, 8'h55, 0, 0, 8'h01);

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            add_n      = vecs[i].add_n;
            clr        = vecs[i].clr;
            host_valid = vecs[i].hv;
            SW         = vecs[i].sw;
            tick();
            check($sformatf("vec%0d_add", i), acc_add, vecs[i].e_add);
            check($sformatf("vec%0d_clr", i), acc_clr, vecs[i].e_clr);
            check($sformatf("vec%0d_ready", i), host_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_src", i), grant_src, vecs[i].e_src);
            check($sformatf("vec%0d_op", i), acc_operand, vecs[i].e_op);
        end

        // Host stream: two back-to-back transfers, 2+HOLDOFF cycles apart.
        host_valid = 1'b1;
        host_data  = 8'hAA;
        wait_add(4, t1);
        check("host1_op", acc_operand, 8'hAA);
        check("host1_ready", host_ready, 1);
        check("host1_src", grant_src, 1);
        tick();
        host_data = 8'h55;
        wait_add(8, t2);
        check("host_gap", t2 - t1, 4);
        check("host2_op", acc_operand, 8'h55);
        check("host2_ready", host_ready, 1);
        host_valid = 1'b0;
        repeat (6) tick();

        // Reset mid-command aborts the strobe sequence and discards a pending clear.
        host_valid = 1'b1;
        host_data  = 8'h11;
        tick();
        check("abort_add_issued", acc_add, 1);
        host_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rst = 1'b1;
        tick();
        check("abort_no_add", acc_add, 0);
        check("abort_no_clr", acc_clr, 0);
        check("abort_no_ready", host_ready, 0);
        check("abort_op_reset", acc_operand, 8'h00);
        rst = 1'b0;
        a0 = add_cnt;
        c0 = clr_cnt;
        repeat (8) tick();
        check("abort_clr_discarded", clr_cnt, c0);
        check("abort_add_quiet", add_cnt, a0);

        // Contention: button, host, button, host, then button wins again from host.
        SW = 8'h3C;
        contend(1'b0);
        add_n = 1'b0;
        wait_add(12, t1);
        check("solo_btn_src", grant_src, 0);
        check("solo_btn_op", acc_operand, 8'h3C);
        add_n = 1'b1;
        repeat (8) tick();
        contend(1'b1);

        // Clear during HOLDOFF with btn_pend set.
        SW = 8'h77;
        add_n = 1'b0;
        repeat (4) tick();
        host_valid = 1'b1;
        host_data  = 8'h5A;
        tick();
        check("clr_host_add", acc_add, 1);
        check("clr_host_op", acc_operand, 8'h5A);
        host_valid = 1'b0;
        tick();
        check("clr_holdoff_quiet", acc_add, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_not_yet", acc_clr, 0);
        tick();
        check("clr_idle_return", acc_clr, 0);
        tick();
        check("clr_strobe", acc_clr, 1);
        check("clr_no_add_with_clr", acc_add, 0);
        tick();
        check("clr_gap_add", acc_add, 0);
        check("clr_gap_clr", acc_clr, 0);
        tick();
        check("clr_then_btn_add", acc_add, 1);
        check("clr_then_btn_src", grant_src, 0);
        check("clr_then_btn_op", acc_operand, 8'h77);
        add_n = 1'b1;
        repeat (8) tick();

        // Drop: a held clear starves the add port while two presses arrive.
        SW = 8'h09;
        a0 = add_cnt;
        d0 = drop_cnt;
        clr = 1'b1;
        repeat (4) tick();
        for (int p = 0; p < 2; p++) begin
            add_n = 1'b0;
            repeat (8) tick();
            add_n = 1'b1;
            repeat (8) tick();
        end
        check("drop_no_add_while_hogged", add_cnt, a0);
        check("drop_pulse_once", drop_cnt, d0 + 1);
        clr = 1'b0;
        repeat (12) tick();
        check("drop_single_btn_add", add_cnt, a0 + 1);
        check("drop_btn_src", grant_src, 0);
        check("drop_btn_op", acc_operand, 8'h09);

        // 512 presses on the zero-holdoff instance.
        for (int p = 0; p < 512; p++) begin
            add_n2 = 1'b0;
            repeat (7) tick();
            add_n2 = 1'b1;
            repeat (7) tick();
        end
        repeat (10) tick();
        check("press512_count", add2_cnt, 512);
        check("press512_operand", bad2_op, 0);
        check("press512_no_drop", drop2_cnt, 0);
        check("never_add_and_clr", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
